// File: rtl/rom_read_responder_pkg.sv
// Shared widths, FSM state encoding and helpers for the ROM read responder.
package rom_read_responder_pkg;

  localparam int DEF_DATA_W = 14;
  localparam int DEF_ADDR_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  localparam logic [DEF_ADDR_W-1:0] JMP_NONE = {DEF_ADDR_W{1'b1}};

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rom_read_responder_rom_array.sv
// Program image, synchronous read: q is mem[addr] one cycle after addr; no backpressure.
// The array starts cleared; the image is placed into mem before use.
import rom_read_responder_pkg::*;

module rom_array #(
  parameter int    DATA_W    = DEF_DATA_W,
  parameter int    DEPTH     = 4096,
  parameter int    AW        = addr_bits(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    q <= mem[addr];
  end

endmodule

// File: rtl/rom_read_responder.sv
// Fetch-side ROM responder: WAIT_CYCLES before streaming grants, data two cycles after each grant,
// grants follow rom_rd with no other backpressure. Optional ROM_ADDR_CHECK_EN adds addr_err.
import rom_read_responder_pkg::*;

module rom_read_responder #(
  parameter int    DATA_W      = DEF_DATA_W,
  parameter int    ADDR_W      = DEF_ADDR_W,
  parameter int    DEPTH       = 4096,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = "rom.hex"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rom_rd,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              rom_rd_garant,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
`ifdef ROM_ADDR_CHECK_EN
  output logic              addr_err,
`endif
  output logic              busy
);

  localparam int         AW        = addr_bits(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt, wait_cnt_nxt;
  logic              addr_pend;
  logic [AW-1:0]     rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] data_hold;

  // Addresses beyond the implemented depth fold back into the array.
  assign rom_addr = AW'({{(32-ADDR_W){1'b0}}, addr_in} % DEPTH);

  rom_array #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .q    (rom_q)
  );

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (rom_rd) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = ST_GRANT;
          end else begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (!rom_rd)              state_nxt = ST_IDLE;
        else if (wait_cnt == 4'd1) state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (!rom_rd) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      rom_rd_garant <= 1'b0;
      addr_pend     <= 1'b0;
      data_valid    <= 1'b0;
      data_hold     <= '0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= wait_cnt_nxt;
      rom_rd_garant <= (state_nxt == ST_GRANT);
      addr_pend     <= rom_rd_garant & rom_rd;
      data_valid    <= addr_pend;
      data_hold     <= data_out;
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef ROM_ADDR_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) addr_err <= 1'b0;
    else       addr_err <= addr_pend && (32'(addr_in) >= DEPTH);
  end

  // The ROM register captures the word on the strobe edge; between strobes the last word is held.
  assign data_out = data_valid ? (addr_err ? '0 : rom_q) : data_hold;
`else
  assign data_out = data_valid ? rom_q : data_hold;
`endif

endmodule

// File: tb/tb_rom_read_responder.sv
// Randomised fetch-unit stimulus against a cycle-level reference model with a data scoreboard.
module tb_rom_read_responder;

  localparam int DATA_W = 14;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 256;
  localparam int W      = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              rom_rd;
  logic [ADDR_W-1:0] addr_in;
  logic              rom_rd_garant;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;
`ifdef ROM_ADDR_CHECK_EN
  logic              addr_err;
`endif

  rom_read_responder #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (W),
    .INIT_FILE   ("")
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_rd        (rom_rd),
    .addr_in       (addr_in),
    .rom_rd_garant (rom_rd_garant),
    .data_out      (data_out),
    .data_valid    (data_valid),
`ifdef ROM_ADDR_CHECK_EN
    .addr_err      (addr_err),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              e;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] model [DEPTH];
  int                checks   = 0;
  int                failures = 0;

  // Reference model: grant after W+1 consecutive sampled requests, busy while the last sample was high,
  // one data strobe two cycles after every cycle in which grant and request are both high.
  bit                cur_rd, exp_gnt, exp_busy, exp_dv, hs1, hs2, mon_en, seq_mode;
  int                run, seq_addr;
  logic [DATA_W-1:0] last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t expect_for(input logic [ADDR_W-1:0] a);
    exp_t r;
`ifdef ROM_ADDR_CHECK_EN
    if (int'(a) >= DEPTH) begin
      r.d = '0;
      r.e = 1'b1;
    end else begin
      r.d = model[int'(a)];
      r.e = 1'b0;
    end
`else
    r.d = model[int'(a) % DEPTH];
    r.e = 1'b0;
`endif
    return r;
  endfunction

  task automatic model_clear();
    cur_rd = 0; run = 0; hs1 = 0; hs2 = 0;
    exp_gnt = 0; exp_busy = 0; exp_dv = 0;
    last_data = '0;
    sb.delete();
  endtask

  task automatic tick(input bit rd);
    logic [ADDR_W-1:0] a;
    @(posedge clk);
    #1;
    if (cur_rd) begin
      if (run < 1000) run++;
    end else begin
      run = 0;
    end
    exp_busy = cur_rd;
    exp_gnt  = (run >= W + 1);
    exp_dv   = hs2;
    if (hs1) begin
      a = seq_mode ? ADDR_W'(seq_addr) : ADDR_W'($urandom_range(0, 4095));
      seq_addr++;
      addr_in = a;
      sb.push_back(expect_for(a));
    end else begin
      addr_in = ADDR_W'($urandom);
    end
    cur_rd = rd;
    rom_rd = rd;
    hs2    = hs1;
    hs1    = exp_gnt && rd;
  endtask

  task automatic do_reset();
    mon_en = 0;
    reset  = 1'b1;
    rom_rd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    mon_en = 1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("garant", rom_rd_garant, exp_gnt);
      check("busy", busy, exp_busy);
      check("data_valid", data_valid, exp_dv);
      if (data_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_data: got %0h with no word pending at %0t", data_out, $time);
        end else begin
          e = sb.pop_front();
          check("data_out", data_out, e.d);
`ifdef ROM_ADDR_CHECK_EN
          check("addr_err", addr_err, e.e);
`endif
        end
        last_data = data_out;
      end else begin
        check("data_hold", data_out, last_data);
`ifdef ROM_ADDR_CHECK_EN
        check("addr_err_idle", addr_err, 1'b0);
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mon_en   = 0;
    seq_mode = 0;
    seq_addr = 0;
    model_clear();
    reset    = 1'b1;
    rom_rd   = 1'b0;
    addr_in  = '0;
    #1;
    for (int i = 0; i < DEPTH; i++) model[i] = DATA_W'($urandom);
    model[0] = 14'h0A5;
    for (int i = 0; i < DEPTH; i++) dut.u_rom.mem[i] = model[i];

    check("reset_garant", rom_rd_garant, 1'b0);
    check("reset_valid", data_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_data", data_out, '0);
    do_reset();

    // First-grant latency and a five-word stream from address 0.
    seq_mode = 1;
    seq_addr = 0;
    repeat (8) tick(1'b1);
    repeat (4) tick(1'b0);

    // Requests abandoned during the wait window.
    tick(1'b1); tick(1'b0); tick(1'b0);
    tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);

    // Single grant with the request dropped right after it.
    repeat (4) tick(1'b1);
    repeat (4) tick(1'b0);

    // First address past the implemented depth.
    seq_addr = 'h100;
    repeat (4) tick(1'b1);
    repeat (4) tick(1'b0);

    seq_mode = 0;
    repeat (600) tick(($urandom_range(0, 9) < 7) ? cur_rd : !cur_rd);

    // Asynchronous reset in the middle of a grant stream.
    repeat (6) tick(1'b1);
    mon_en = 0;
    #1;
    check("garant_before_reset", rom_rd_garant, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("async_garant", rom_rd_garant, 1'b0);
    check("async_valid", data_valid, 1'b0);
    check("async_busy", busy, 1'b0);
    check("async_data", data_out, '0);
    do_reset();
    tick(1'b0);
    tick(1'b0);

    repeat (300) tick(($urandom_range(0, 9) < 7) ? cur_rd : !cur_rd);
    repeat (6) tick(1'b0);
    @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
